chunked_add: RTL

//  Multi-cycle wide adder/subtractor for the large-multiplication datapath (final carry-propagate stage after Wallace reduction).

---
 rtl/chunked_add_pkg.sv | 20 ++
 rtl/chunked_add_chunk_add.sv | 14 +
 rtl/chunked_add.sv | 96 +++++++++
 3 files changed

// File: rtl/chunked_add_pkg.sv
// Shared definitions for the chunked carry-propagate adder: FSM encoding and
// sizing helpers.
package chunked_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width for n chunks, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_add_chunk_add.sv
// Combinational CHUNK-bit slice adder: {cout, s} = a + b + cin.
module chunk_add #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);

endmodule

// File: rtl/chunked_add.sv
// Multi-cycle wide add/subtract: one CHUNK slice per cycle, LSB first, with the
// carry held in a register between slices so no full-width carry chain exists.
module chunked_add
    import chunked_add_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_w(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic                           carry;
    logic [NCHUNK-1:0][CHUNK-1:0]   a_q, b_q, s_q;
    logic [CHUNK-1:0]               sum_k;
    logic                           c_k;

    chunk_add #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .cin  (carry),
        .s    (sum_k),
        .cout (c_k)
    );

    assign s = s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            s_q       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtract as a + ~b + 1: invert B once here, seed carry with 1.
                        a_q      <= a;
                        b_q      <= b ^ {WIDTH{sub}};
                        carry    <= sub | cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s_q[cnt] <= sum_k;
                    carry    <= c_k;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        cout      <= c_k;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
